// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder.
// Holds the FSM state encoding and the chunk-count and index-width helpers.
// Imported by the top level and the benches.
package seq_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices in a WIDTH-bit operand
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register width; a single-chunk adder still needs a 1-bit index
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full_adder cells.
// Latency: combinational.
// Backpressure: none.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;
  assign co     = w_c[CHUNK];

  for (genvar g = 0; g < CHUNK; g++) begin : g_bit
    full_adder u_fa (
      .a  (a[g]),
      .b  (b[g]),
      .ci (w_c[g]),
      .s  (s[g]),
      .co (w_c[g+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the chunk ripple adder.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle with a registered carry.
// Latency: result valid WIDTH/CHUNK edges after operand accept.
// Backpressure: result held in DONE until out_ready; no operands taken outside IDLE.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_last;

  assign w_a_sl = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_sl = r_bx[r_idx*CHUNK +: CHUNK];
  assign w_last = (r_idx == IW'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a  (w_a_sl),
    .b  (w_b_sl),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign in_ready  = (r_state == ST_IDLE) & ~rst;
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, step through chunks in BUSY, wait for consumer in DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and per-chunk accumulation; results hold until the next op writes them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_bx    <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_bx    <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        ST_BUSY: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_s;
          r_carry                     <= w_co;
          r_idx                       <= r_idx + IW'(1);
          if (w_last) begin
            r_cout <= w_co;
            // Top bit of the final slice is the result sign bit
            r_ovf  <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) & (w_s[CHUNK-1] != r_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
